// File: rtl/seq_signed_or_unsigned_mul.sv
// seq_signed_or_unsigned_mul
// Iterative shift-and-add multiplier: one product bit per clock, signed or
// unsigned n-bit operands, 2n-bit product, valid/ready handshakes on both sides.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   up_valid    operand set present on a, b, signed_mul
//   up_ready    block can accept operands (IDLE)
//   a, b        n-bit multiplicand / multiplier
//   signed_mul  1 = two's-complement operands and result, 0 = unsigned
//   down_valid  res holds a finished product (DONE)
//   down_ready  consumer takes the product
//   res         registered 2n-bit product
//   busy        high in RUN or DONE
module seq_signed_or_unsigned_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           down_valid,
    input  logic           down_ready,
    output logic [2*n-1:0] res,
    output logic           busy
);

    localparam int W2 = 2 * n;
    localparam int CW = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [n-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]   acc_q,   acc_d;
    logic            neg_q,   neg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W2-1:0]   res_q,   res_d;

    logic [n-1:0]    mag_a, mag_b;
    logic [n:0]      sum;
    logic [W2-1:0]   acc_step;
    logic            last_step;

    // Magnitudes are exact in n unsigned bits, including the most negative value.
    assign mag_a = (signed_mul && a[n-1]) ? (~a + n'(1)) : a;
    assign mag_b = (signed_mul && b[n-1]) ? (~b + n'(1)) : b;

    // Shift-right accumulator: the multiplier occupies the low half of acc and
    // is consumed LSB first while the partial product grows into the high half,
    // so only an n-bit adder (plus carry) is needed per step.
    assign sum       = {1'b0, acc_q[W2-1:n]} + {1'b0, (acc_q[0] ? mcand_q : {n{1'b0}})};
    assign acc_step  = {sum, acc_q[n-1:1]};
    assign last_step = (cnt_q == CW'(n - 1));

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (up_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    mcand_d = mag_a;
                    acc_d   = {{n{1'b0}}, mag_b};
                    neg_d   = signed_mul & (a[n-1] ^ b[n-1]);
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = DONE;
                    res_d   = neg_q ? (~acc_step + W2'(1)) : acc_step;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign up_ready   = (state_q == IDLE);
    assign down_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res        = res_q;

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
module tb_seq_signed_or_unsigned_mul;

    logic clk = 1'b0;
    logic rst;

    logic        uv8, ur8, s8, dv8, dr8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;

    logic        uv4, ur4, s4, dv4, dr4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  r4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_signed_or_unsigned_mul #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .up_valid(uv8), .up_ready(ur8), .a(a8), .b(b8),
        .signed_mul(s8), .down_valid(dv8), .down_ready(dr8), .res(r8), .busy(busy8)
    );

    seq_signed_or_unsigned_mul #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .up_valid(uv4), .up_ready(ur4), .a(a4), .b(b4),
        .signed_mul(s4), .down_valid(dv4), .down_ready(dr4), .res(r4), .busy(busy4)
    );

    // Reference: mathematical product of the interpreted operands, low 2w bits.
    function automatic longint unsigned ref_prod(input int w, input longint unsigned av,
                                                 input longint unsigned bv, input bit s);
        longint sa = longint'(av);
        longint sb = longint'(bv);
        if (s && av >= (64'd1 << (w - 1))) sa = sa - (longint'(1) << w);
        if (s && bv >= (64'd1 << (w - 1))) sb = sb - (longint'(1) << w);
        return longint'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble8();
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        s8  = 1'($urandom);
        uv8 = 1'($urandom);
    endtask

    // One n=8 operation from IDLE: latency, result, optional backpressure hold
    // with input toggling, then output handshake.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input longint unsigned exp, input bit toggle, input int hold);
        int lat = 0;
        chk("up_ready_idle", ur8, 1);
        a8 = av; b8 = bv; s8 = sv; uv8 = 1'b1; dr8 = 1'b0;
        @(posedge clk); @(negedge clk);
        uv8 = 1'b0;
        while (!dv8 && lat < 40) begin
            chk("busy_run", busy8, 1);
            if (toggle) scramble8();
            @(posedge clk); lat++; @(negedge clk);
        end
        uv8 = 1'b0;
        chk("latency", lat, 8);
        chk("res", r8, exp);
        for (int i = 0; i < hold; i++) begin
            if (toggle) scramble8();
            @(posedge clk); @(negedge clk);
            chk("hold_res", r8, exp);
            chk("hold_dv", dv8, 1);
            chk("hold_ur", ur8, 0);
        end
        uv8 = 1'b0;
        dr8 = 1'b1;
        @(posedge clk); @(negedge clk);
        dr8 = 1'b0;
        chk("dv_drop", dv8, 0);
        chk("res_kept", r8, exp);
        chk("busy_idle", busy8, 0);
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic sv);
        int lat = 0;
        a4 = av; b4 = bv; s4 = sv; uv4 = 1'b1; dr4 = 1'b0;
        @(posedge clk); @(negedge clk);
        uv4 = 1'b0;
        while (!dv4 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("res4", r4, ref_prod(4, av, bv, sv));
        dr4 = 1'b1;
        @(posedge clk); @(negedge clk);
        dr4 = 1'b0;
    endtask

    initial begin
        longint unsigned exp_q[$];
        int acc_cyc[$];
        int seen;

        rst = 1'b1;
        uv8 = 1'b0; dr8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        uv4 = 1'b0; dr4 = 1'b0; s4 = 1'b0; a4 = '0; b4 = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_res", r8, 0);
        chk("rst_dv", dv8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_ur", ur8, 1);

        // Directed values
        run8(8'd200, 8'd3,   1'b0, 16'h0258, 1'b0, 0);
        run8(8'hFF,  8'hFF,  1'b0, 16'hFE01, 1'b0, 0);
        run8(8'hFD,  8'h05,  1'b1, 16'hFFF1, 1'b0, 0);
        run8(8'hFD,  8'h05,  1'b0, 16'h04F1, 1'b0, 0);
        run8(8'h80,  8'h80,  1'b1, 16'h4000, 1'b0, 0);
        run8(8'h80,  8'h01,  1'b1, 16'hFF80, 1'b0, 0);
        run8(8'h80,  8'h7F,  1'b1, 16'hC080, 1'b0, 0);
        run8(8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b0, 0);
        run8(8'h00,  8'h80,  1'b1, 16'h0000, 1'b0, 0);

        // Backpressure with inputs toggling during RUN and DONE
        run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1, 5);
        run8(8'h81, 8'h7E, 1'b0, ref_prod(8, 8'h81, 8'h7E, 1'b0), 1'b1, 5);

        // Back-to-back issue with down_ready held high
        dr8 = 1'b1; uv8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        for (int cyc = 0; cyc < 35; cyc++) begin
            if (dv8) begin
                if (exp_q.size() > 0) chk("b2b_res", r8, exp_q.pop_front());
                else chk("b2b_spurious_dv", dv8, 0);
            end
            if (ur8) begin
                exp_q.push_back(ref_prod(8, a8, b8, s8));
                acc_cyc.push_back(cyc);
            end
            @(posedge clk); @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        end
        uv8 = 1'b0;
        chk("b2b_count", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 10);
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            if (dv8) chk("b2b_drain_res", r8, exp_q.pop_front());
            @(posedge clk); @(negedge clk);
        end
        chk("b2b_drained", exp_q.size(), 0);
        dr8 = 1'b0;
        @(posedge clk); @(negedge clk);

        // Reset during RUN
        a8 = 8'h10; b8 = 8'h10; s8 = 1'b0; uv8 = 1'b1;
        @(posedge clk); @(negedge clk);
        uv8 = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ur", ur8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_dv", dv8, 0);
        chk("mid_rst_res", r8, 0);
        seen = 0;
        repeat (12) begin
            if (dv8) seen++;
            @(posedge clk); @(negedge clk);
        end
        chk("mid_rst_no_dv", seen, 0);
        run8(8'd3, 8'd4, 1'b0, 16'h000C, 1'b0, 0);

        // Random n=8 sweep against the reference product
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run8(ra, rb, rs, ref_prod(8, ra, rb, rs), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Exhaustive n=4, both modes
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run4(4'(x), 4'(y), 1'(s));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_signed_or_unsigned_mul.md
# seq_signed_or_unsigned_mul

Iterative shift-and-add multiplier with an FSM controller. It computes the signed or unsigned 2n-bit product of two n-bit operands, one product bit-step per clock. Operands enter through a valid/ready input handshake and the product leaves through a valid/ready output handshake. It replaces the single-cycle combinational multiplier where area matters more than latency: one n-bit adder instead of an n×n array.

## Interface
- `n`, default 8: operand width; legal range n ≥ 2.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `up_valid`  input  1  operand set present on `a`, `b`, `signed_mul`.
- `up_ready`  output  1  block can accept operands.
- `a`  input  n  multiplicand.
- `b`  input  n  multiplier.
- `signed_mul`  input  1  1 = two's-complement operands and result; 0 = unsigned.
- `down_valid`  output  1  `res` holds a finished product.
- `down_ready`  input  1  consumer takes the product.
- `res`  output  2n  product.
- `busy`  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `up_ready`=1.
  - When `up_valid`=1, the operation is accepted:
    - latch `a`, `b`, `signed_mul`;
    - go to RUN and clear the step counter.
  - Otherwise stay in IDLE.
- **Acceptance latching**
  - Signed mode: latch |a| and |b| (two's-complement negate when the MSB is 1). Also latch neg = a[n-1] XOR b[n-1].
  - Unsigned mode: latch a and b unchanged; neg=0.
  - The magnitude of the most negative value (e.g. 8'h80) is 2^(n-1). This fits in n unsigned bits, so the magnitude is exact.
- **RUN**, one step per cycle, step counter k = 0..n-1:
  - if multiplier bit k is 1, add the multiplicand shifted left by k into a 2n-bit accumulator (or use the equivalent shift-right accumulator form);
  - all arithmetic is modulo 2^(2n).
  - After step n-1, go to DONE.
  - On that same edge, `res` loads the accumulator: negated (~acc+1) if neg=1, unchanged otherwise.
- **DONE**
  - `down_valid`=1 and `res` stable.
  - If `down_ready`=1, go to IDLE. Otherwise stay in DONE indefinitely (backpressure).
- **Input rules**
  - `up_ready`=0 in RUN and DONE. `up_valid`, `a`, `b` and `signed_mul` are ignored there, and changes to them do not affect the operation in flight.
- **Result rules**
  - `res` keeps the last product after the output handshake, until the next DONE entry.
  - The result equals the low 2n bits of the mathematical product:
    - signed mode: range −2^(2n−2)+2^(n−1) … 2^(2n−2);
    - unsigned mode: max (2^n−1)^2.
    - No overflow is possible in either mode.

## Timing
- **Reset** (`rst`=1 at an edge): state=IDLE, `res`=0, `down_valid`=0, `busy`=0, `up_ready`=1 from the next cycle. Reset overrides all other events.
- **Reset mid-operation**, in RUN or DONE: the operation is discarded and no `down_valid` pulse occurs.
- **Latency:** acceptance on edge E0 gives `down_valid`=1 after edge E0+n, so it is first visible in cycle n after acceptance.
- **Minimum issue interval:** n+2 cycles.
  - Accept edge, n RUN edges, then the DONE→IDLE edge with `down_ready`=1.
  - The next acceptance can happen on the following edge.
  - There is no overlap of operations.
- **Output handshake:** completes on any edge where `down_valid`=1 and `down_ready`=1. `down_valid` drops on that edge.
- **Input handshake:** completes on any edge where `up_valid`=1 and `up_ready`=1.
- **Outputs:**
  - `up_ready`, `down_valid` and `busy` decode from the registered state only.
  - `up_ready` does not depend combinationally on `down_ready`.
  - `res` is registered.

## Test plan
- **Unsigned basic:** n=8, `signed_mul`=0, a=200, b=3.
  - `res`=16'h0258, with `down_valid` rising exactly 8 cycles after acceptance.
  - Then a=8'hFF, b=8'hFF gives `res`=16'hFE01.
- **Signed mixed sign:** a=8'hFD (−3), b=8'h05 gives `res`=16'hFFF1.
  - Same bit patterns with `signed_mul`=0 give 16'h04F1.
- **Signed extremes:**
  - a=b=8'h80 gives 16'h4000;
  - a=8'h80, b=8'h01 gives 16'hFF80;
  - a=8'h80, b=8'h7F gives 16'hC080;
  - a=b=8'hFF gives 16'h0001;
  - a=0, b=8'h80 gives 16'h0000.
- **Backpressure and input isolation:**
  - Hold `down_ready`=0 for 5 cycles in DONE: `res` is stable, `down_valid`=1, `up_ready`=0 throughout.
  - Toggling a, b, `signed_mul` and `up_valid` during RUN/DONE does not alter `res`.
  - After release, back-to-back operations run at an interval of n+2 cycles.
- **Reset mid-RUN:**
  - Assert `rst` at step 4 of a=8'h10, b=8'h10: the next cycle shows IDLE, `res`=0, `busy`=0, and no `down_valid`.
  - A new operation (3×4) then yields 16'h000C.
- **Random sweep:** for n=4 exhaustively (all a, b, both modes) and n=8 randomly, compare `res` against a reference product.
